// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Brief    : RV32I opcodes, load/store funct3 encodings and MEM-stage FSM states
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational load extraction/extension and store lane replication
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        load_data = rdata;
        case (funct3)
            F3_LB:   load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_LBU:  load_data = {24'd0, w_shifted[7:0]};
            F3_LHU:  load_data = {16'd0, w_shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

    // Reserved funct3 values are reported as misaligned so no request is issued.
    always_comb begin
        wdata      = store_data;
        be         = 4'b0000;
        misaligned = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB: begin
                    wdata = {4{store_data[7:0]}};
                    be    = 4'b0001 << addr_lo;
                end
                F3_SH: begin
                    wdata      = {2{store_data[15:0]}};
                    be         = 4'b0011 << addr_lo;
                    misaligned = addr_lo[0];
                end
                F3_SW: begin
                    be         = 4'b1111;
                    misaligned = |addr_lo;
                end
                default: misaligned = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: misaligned = 1'b0;
                F3_LH, F3_LHU: misaligned = addr_lo[0];
                F3_LW:         misaligned = |addr_lo;
                default:       misaligned = 1'b1;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/core_mem_stage.sv
// ============================================================================
// Module   : core_mem_stage
// Brief    : Memory-access stage: dmem req/gnt/rvalid FSM, stall and MEM/WB register
// Revision : 1.0
// ============================================================================
`default_nettype none

module core_mem_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BE_W = XLEN / 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_stall,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [BE_W-1:0] o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic            o_wb_reg_write,
    output logic [XLEN-1:0] o_wb_rd_din,
    output logic            o_misaligned
);

    mem_state_e r_state;
    mem_state_e w_state_nxt;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic            w_misaligned;
    logic            w_issue;
    logic            w_wb_we;
    logic [XLEN-1:0] w_wdata;
    logic [BE_W-1:0] w_be;
    logic [XLEN-1:0] w_load_data;

    assign w_is_load  = i_valid && (i_opcode == OPCODE_LOAD);
    assign w_is_store = i_valid && (i_opcode == OPCODE_STORE);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_issue    = w_is_mem && !w_misaligned;

    lsu_align u_lsu_align (
        .funct3     (i_funct3),
        .is_store   (w_is_store),
        .addr_lo    (i_alu_result[1:0]),
        .store_data (i_store_data),
        .rdata      (i_dmem_rdata),
        .wdata      (w_wdata),
        .be         (w_be),
        .load_data  (w_load_data),
        .misaligned (w_misaligned)
    );

    always_comb begin
        w_state_nxt = r_state;
        o_dmem_req  = 1'b0;
        o_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    o_dmem_req  = 1'b1;
                    o_stall     = 1'b1;
                    w_state_nxt = i_dmem_gnt ? WAIT : REQ;
                end
            end
            REQ: begin
                o_dmem_req = 1'b1;
                o_stall    = 1'b1;
                if (i_dmem_gnt) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Stall releases in the rvalid cycle so EX/MEM advances on that edge.
                o_stall = !i_dmem_rvalid;
                if (i_dmem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (i_rst) begin
            o_dmem_req = 1'b0;
            o_stall    = 1'b0;
        end
    end

    assign o_dmem_we    = o_dmem_req && w_is_store;
    assign o_dmem_addr  = o_dmem_req ? {i_alu_result[XLEN-1:2], 2'b00} : '0;
    assign o_dmem_be    = o_dmem_req ? w_be : '0;
    assign o_dmem_wdata = o_dmem_req ? w_wdata : '0;

    assign w_wb_we = i_valid && i_reg_write && (i_rd != 5'd0) && !w_is_store
                     && !(w_is_mem && w_misaligned);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            o_wb_valid     <= 1'b0;
            o_wb_rd        <= 5'd0;
            o_wb_reg_write <= 1'b0;
            o_wb_rd_din    <= '0;
            o_misaligned   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            o_misaligned <= !o_stall && w_is_mem && w_misaligned;
            if (!o_stall) begin
                o_wb_valid     <= i_valid;
                o_wb_rd        <= i_rd;
                o_wb_reg_write <= w_wb_we;
                o_wb_rd_din    <= w_is_load ? w_load_data : i_alu_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_mem_stage.sv
// ============================================================================
// Module   : tb_core_mem_stage
// Brief    : Self-checking bench for core_mem_stage with directed and random ops
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_core_mem_stage;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic [31:0] i_alu_result;
    logic [31:0] i_store_data;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic        o_wb_reg_write;
    logic [31:0] o_wb_rd_din;
    logic        o_misaligned;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_mem_stage #(.XLEN(32), .BE_W(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_valid        (i_valid),
        .i_opcode       (i_opcode),
        .i_funct3       (i_funct3),
        .i_rd           (i_rd),
        .i_reg_write    (i_reg_write),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .o_stall        (o_stall),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_be      (o_dmem_be),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_gnt     (i_dmem_gnt),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_wb_valid     (o_wb_valid),
        .o_wb_rd        (o_wb_rd),
        .o_wb_reg_write (o_wb_reg_write),
        .o_wb_rd_din    (o_wb_rd_din),
        .o_misaligned   (o_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Access size in bytes; 0 marks a reserved encoding.
    function automatic int ref_size(input bit st, input logic [2:0] f3);
        case (f3)
            3'd0:       return 1;
            3'd1:       return 2;
            3'd2:       return 4;
            3'd4, 3'd5: return st ? 0 : ((f3 == 3'd4) ? 1 : 2);
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_misaligned(input bit st, input logic [2:0] f3, input logic [31:0] addr);
        int sz = ref_size(st, f3);
        if (sz == 0) return 1'b1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        longint lane = longint'(addr % 4);
        longint sz   = longint'(ref_size(1'b0, f3));
        longint v;
        if (sz == 4) return rdata;
        v = (longint'(rdata) / (longint'(1) << (8 * lane))) % (longint'(1) << (8 * sz));
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz)) + (longint'(1) << 32);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        longint v;
        if (f3 == 3'd0)      v = longint'(d % 256) * 64'h0101_0101;
        else if (f3 == 3'd1) v = longint'(d % 65536) * 64'h0001_0001;
        else                 v = longint'(d);
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = ref_size(1'b1, f3);
        if (sz == 4) return 32'hF;
        return 32'(((1 << sz) - 1) << (addr % 4));
    endfunction

    // Called just after a rising edge; leaves just after the edge that loads MEM/WB.
    task automatic do_op(input string tag, input bit valid, input logic [6:0] op,
                         input logic [2:0] f3, input logic [4:0] rd, input bit rw,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int gdly, input int rdly);
        bit is_ld  = valid && (op == OPCODE_LOAD);
        bit is_st  = valid && (op == OPCODE_STORE);
        bit is_mem = is_ld || is_st;
        bit mis    = is_mem && ref_misaligned(is_st, f3, addr);
        int stalls = 0;
        i_valid      = valid;
        i_opcode     = op;
        i_funct3     = f3;
        i_rd         = rd;
        i_reg_write  = rw;
        i_alu_result = addr;
        i_store_data = data;
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        if (is_mem && !mis) begin
            for (int k = 0; k <= gdly; k++) begin
                i_dmem_gnt = (k == gdly);
                #1;
                check({tag, ".req"}, o_dmem_req, 1'b1);
                check({tag, ".addr"}, o_dmem_addr, {addr[31:2], 2'b00});
                check({tag, ".we"}, o_dmem_we, is_st);
                if (is_st) begin
                    check({tag, ".be"}, o_dmem_be, ref_be(f3, addr));
                    check({tag, ".wdata"}, o_dmem_wdata, ref_wdata(f3, data));
                end
                stalls += int'(o_stall);
                @(posedge clk); #1;
            end
            i_dmem_gnt = 1'b0;
            for (int j = 1; j <= rdly; j++) begin
                i_dmem_rvalid = (j == rdly);
                i_dmem_rdata  = (j == rdly) ? rdata : $urandom;
                #1;
                check({tag, ".req_wait"}, o_dmem_req, 1'b0);
                stalls += int'(o_stall);
                @(posedge clk); #1;
            end
            i_dmem_rvalid = 1'b0;
            check({tag, ".stall_cycles"}, 32'(stalls), 32'(gdly + rdly));
        end else begin
            #1;
            check({tag, ".noreq"}, o_dmem_req, 1'b0);
            check({tag, ".nostall"}, o_stall, 1'b0);
            @(posedge clk); #1;
        end
        check({tag, ".wb_valid"}, o_wb_valid, valid);
        check({tag, ".misaligned"}, o_misaligned, mis);
        if (valid) begin
            check({tag, ".wb_rd"}, o_wb_rd, rd);
            check({tag, ".wb_we"}, o_wb_reg_write, rw && rd != 0 && !is_st && !mis);
            if (!is_st && !mis)
                check({tag, ".wb_din"}, o_wb_rd_din, is_ld ? ref_load(f3, addr, rdata) : addr);
        end else begin
            check({tag, ".wb_we_idle"}, o_wb_reg_write, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 0; i_opcode = 0; i_funct3 = 0; i_rd = 0; i_reg_write = 0;
        i_alu_result = 0; i_store_data = 0;
        i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
        @(posedge clk); @(posedge clk); #1;
        check("rst.wb_valid", o_wb_valid, 0);
        check("rst.wb_we", o_wb_reg_write, 0);
        check("rst.wb_din", o_wb_rd_din, 0);
        check("rst.req", o_dmem_req, 0);
        check("rst.stall", o_stall, 0);
        check("rst.misaligned", o_misaligned, 0);
        rst = 1'b0;

        do_op("add", 1, OPCODE_R, 3'd0, 5'd5, 1, 32'h0000_1234, 0, 0, 0, 1);
        do_op("lb", 1, OPCODE_LOAD, F3_LB, 5'd6, 1, 32'h103, 0, 32'h80FF_0000, 0, 2);
        do_op("sh", 1, OPCODE_STORE, F3_SH, 5'd7, 0, 32'h202, 32'hABCD_1234, 0, 3, 1);
        do_op("lw_mis", 1, OPCODE_LOAD, F3_LW, 5'd8, 1, 32'h106, 0, 0, 0, 1);
        do_op("lhu", 1, OPCODE_LOAD, F3_LHU, 5'd9, 1, 32'h2, 0, 32'h8001_0000, 1, 1);
        do_op("sw", 1, OPCODE_STORE, F3_SW, 5'd0, 0, 32'h8, 32'hDEAD_BEEF, 0, 0, 1);
        do_op("x0", 1, OPCODE_LOAD, F3_LW, 5'd0, 1, 32'h40, 0, 32'h1111_2222, 0, 1);

        // Reset while waiting on a response, then a stray rvalid.
        i_valid = 1; i_opcode = OPCODE_LOAD; i_funct3 = F3_LW; i_rd = 5'd3;
        i_reg_write = 1; i_alu_result = 32'h10; i_dmem_gnt = 1;
        @(posedge clk); #1;
        i_dmem_gnt = 0;
        rst = 1'b1;
        #1;
        check("rstw.req", o_dmem_req, 0);
        check("rstw.stall", o_stall, 0);
        check("rstw.wb_valid", o_wb_valid, 0);
        check("rstw.wb_din", o_wb_rd_din, 0);
        @(posedge clk); #1;
        rst = 1'b0; i_valid = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFE_F00D;
        #1;
        check("stray.stall", o_stall, 0);
        check("stray.req", o_dmem_req, 0);
        @(posedge clk); #1;
        i_dmem_rvalid = 0;
        check("stray.wb_valid", o_wb_valid, 0);
        check("stray.wb_we", o_wb_reg_write, 0);
        do_op("post_rst_lw", 1, OPCODE_LOAD, F3_LW, 5'd4, 1, 32'h20, 0, 32'h1357_9BDF, 1, 2);

        for (int n = 0; n < 60; n++) begin
            int sel = $urandom_range(0, 9);
            bit v = (sel != 0);
            logic [6:0] op;
            logic [2:0] f3;
            logic [31:0] a = $urandom;
            if (sel <= 4)      op = OPCODE_LOAD;
            else if (sel <= 7) op = OPCODE_STORE;
            else if (sel == 8) op = OPCODE_R;
            else               op = OPCODE_AUIPC;
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (op == OPCODE_STORE)   f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 3));
                if (f3 == 3'd3) f3 = 3'($urandom_range(4, 5));
            end
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_op($sformatf("rnd%0d", n), v, op, f3, 5'($urandom), 1'($urandom),
                  a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
